inc_serial: RTL and testbench
=============================

Name: inc_serial

Overview:
Multi-cycle 20-bit incrementer for the ALU arithmetic group. It is the counterpart of the combinational decrementer and adds +1 instead of −1.
- Processes the operand one CHUNK_WIDTH slice per clock, LSB slice first, carry propagating through a registered carry bit.
- Uses a start/busy/done handshake, so the sequencer can overlap other work while it runs.
- Reports a carry-out flag and a zero flag.

Parameters:
- DATA_WIDTH, 20, operand/result width in bits.
- CHUNK_WIDTH, 4, bits processed per cycle; DATA_WIDTH must be an integer multiple of it.
- N_CHUNKS, DATA_WIDTH/CHUNK_WIDTH (5), derived (localparam), number of processing cycles.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE.
- data_input  input  DATA_WIDTH  operand; sampled on the edge that accepts start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; result valid.
- incremented_output  output  DATA_WIDTH  result; held until the next completion.
- carry_out  output  1  set when the increment wrapped past all-ones.
- zero_flag  output  1  set when the result is all zeros.

Behaviour:
- Reset: rst_n low forces the following immediately, regardless of clk; recovery happens on the first edge with rst_n high.
  - state=IDLE, busy=0, done=0
  - incremented_output=0, carry_out=0, zero_flag=0
  - internal work register, chunk index and carry bit all cleared
- State IDLE:
  - start=1 at an edge: work <= data_input, idx <= 0, carry <= 1, state <= CALC.
  - start=0: remain in IDLE.
- State CALC, on each edge:
  - Compute {c, s} = work[idx chunk] + carry (CHUNK_WIDTH+1 bits).
  - Write s into that chunk of work and set carry <= c.
  - If idx == N_CHUNKS-1: state <= DONE and update the registered outputs:
    - incremented_output <= final work
    - carry_out <= c
    - zero_flag <= (final work == 0)
  - Otherwise idx <= idx+1.
- State DONE: done=1 for exactly this one cycle; next edge goes to IDLE unconditionally.
- Latency: start sampled at edge E0, last chunk at edge E_N_CHUNKS (E5 by default). done is high in the cycle after E5, and the next start can be accepted at E7. busy is high between E0 and E5.
- start while in CALC or DONE: ignored, with no queuing. data_input changes after E0 have no effect.
- Outputs are not modified during CALC; incremented_output still shows the previous result until the completing edge.
- Arithmetic: modulo 2^DATA_WIDTH. carry_out=1 if and only if data_input was all ones; zero_flag and carry_out are then both 1.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and outputs return to reset values.

Optional Feature:
Macro INC_SERIAL_EARLY_EXIT_EN.
- Defined: in CALC, if the chunk just processed produced c=0, the remaining chunks are unchanged. The block therefore jumps to DONE on that same edge, updating outputs from work with the new chunk merged in. carry_out=0 and zero_flag is computed as usual. Latency becomes k+1 cycles, where k is the index of the first chunk that is not all ones, with a maximum of N_CHUNKS.
- Undefined: fixed latency of N_CHUNKS cycles for every operand.

Test Plan:
- Reset with rst_n=0 mid-cycle, no clock edge needed -> all outputs read 0 immediately. After release with start=0, the block stays idle with busy=0.
- start with data_input=0x10000 -> done after 5 cycles, incremented_output=0x10001, carry_out=0, zero_flag=0. With INC_SERIAL_EARLY_EXIT_EN, done comes after 1 cycle.
- data_input=0xFFFFF -> incremented_output=0x00000, carry_out=1, zero_flag=1, 5 cycles in both builds.
- data_input=0x0FFFF -> 0x10000, carry_out=0; takes 5 cycles (both builds).
- Pulse start again mid-CALC with data_input=0x12345 -> ignored. The first result completes unchanged, then a fresh start at idle gives 0x12346.
- Assert rst_n=0 at cycle 3 of an operation -> no done pulse, outputs zeroed. A new start after release completes normally.

Source files
------------

// File: rtl/inc_serial.sv
// inc_serial: multi-cycle incrementer (+1), one CHUNK_WIDTH slice per clock,
// LSB slice first, with the carry held in a register between slices.
// start/busy/done handshake; reports carry-out (wrap past all-ones) and zero.
//
// Optional build macro: INC_SERIAL_EARLY_EXIT_EN
//   defined   : finish on the first slice that produces no carry
//   undefined : fixed latency of N_CHUNKS cycles for every operand
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; operand captured on the accepting edge
// S_CALC | one slice added per edge; busy high
// S_DONE | single-cycle done pulse; result registers already updated

module inc_serial #(
    parameter int DATA_WIDTH  = 20,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_input,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] incremented_output,
    output logic                  carry_out,
    output logic                  zero_flag
);

    localparam int N_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DATA_WIDTH-1:0]   r_work;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_carry;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_carry_out;
    logic                    r_zero;

    logic [CHUNK_WIDTH-1:0]  w_chunk;
    logic [CHUNK_WIDTH:0]    w_sum;
    logic [DATA_WIDTH-1:0]   w_work_new;
    logic                    w_last;
    logic                    w_finish;

    assign busy               = (r_state == S_CALC);
    assign done               = (r_state == S_DONE);
    assign incremented_output = r_result;
    assign carry_out          = r_carry_out;
    assign zero_flag          = r_zero;

    // Slice adder: add the carry into the current slice and merge it back.
    always_comb begin
        w_chunk    = r_work[int'(r_idx) * CHUNK_WIDTH +: CHUNK_WIDTH];
        w_sum      = {1'b0, w_chunk} + {{CHUNK_WIDTH{1'b0}}, r_carry};
        w_work_new = r_work;
        w_work_new[int'(r_idx) * CHUNK_WIDTH +: CHUNK_WIDTH] = w_sum[CHUNK_WIDTH-1:0];
        w_last     = (r_idx == LAST_IDX);
`ifdef INC_SERIAL_EARLY_EXIT_EN
        // With no carry out of this slice, the upper slices cannot change.
        w_finish   = w_last || !w_sum[CHUNK_WIDTH];
`else
        w_finish   = w_last;
`endif
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (w_finish) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Work register, slice index, carry and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work      <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work  <= data_input;
                        r_idx   <= '0;
                        r_carry <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_work  <= w_work_new;
                    r_carry <= w_sum[CHUNK_WIDTH];
                    if (w_finish) begin
                        r_result    <= w_work_new;
                        r_carry_out <= w_sum[CHUNK_WIDTH];
                        r_zero      <= (w_work_new == '0);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inc_serial.sv
// Testbench for inc_serial: directed vector table, hand-written corner
// sequences (ignored start, reset mid-operation) and random operands checked
// against an arithmetic reference model.

module tb_inc_serial;

    localparam int DW = 20;
    localparam int CW = 4;
    localparam int NC = DW / CW;
    localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] data_input = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] incremented_output;
    logic          carry_out;
    logic          zero_flag;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] m_prev = '0;

    inc_serial #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .data_input         (data_input),
        .busy               (busy),
        .done               (done),
        .incremented_output (incremented_output),
        .carry_out          (carry_out),
        .zero_flag          (zero_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [DW-1:0] res;
        logic          c;
        logic          z;
        int            cyc_fixed;
        int            cyc_early;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: plain modular arithmetic plus the latency rule.
    function automatic int model_cycles(input logic [DW-1:0] d);
`ifdef INC_SERIAL_EARLY_EXIT_EN
        logic [DW-1:0] t;
        t = d;
        for (int k = 0; k < NC; k++) begin
            if (t[CW-1:0] != {CW{1'b1}}) return k + 1;
            t = t >> CW;
        end
        return NC;
`else
        return NC;
`endif
    endfunction

    // One complete operation; optionally pulses start again at cycle poke_at.
    task automatic run_op(input string nm, input logic [DW-1:0] d, input logic [DW-1:0] er,
                          input logic ec, input logic ez, input int ecyc, input int poke_at);
        int  cyc;
        bit  seen;
        @(negedge clk);
        start      = 1'b1;
        data_input = d;
        @(posedge clk); #1;
        start      = 1'b0;
        data_input = DW'($urandom);
        check({nm, " busy after start"}, {31'd0, busy}, 32'd1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                check({nm, " result held in calc"}, {12'd0, incremented_output}, {12'd0, m_prev});
                data_input = DW'($urandom);
                if (cyc == poke_at) begin
                    start      = 1'b1;
                    data_input = 20'h12345;
                end
            end
        end
        start = 1'b0;
        check({nm, " done seen"}, {31'd0, seen}, 32'd1);
        check({nm, " latency"}, 32'(cyc), 32'(ecyc));
        check({nm, " result"}, {12'd0, incremented_output}, {12'd0, er});
        check({nm, " carry_out"}, {31'd0, carry_out}, {31'd0, ec});
        check({nm, " zero_flag"}, {31'd0, zero_flag}, {31'd0, ez});
        check({nm, " busy at done"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check({nm, " done one cycle"}, {31'd0, done}, 32'd0);
        check({nm, " idle after done"}, {31'd0, busy}, 32'd0);
        check({nm, " result kept"}, {12'd0, incremented_output}, {12'd0, er});
        m_prev = er;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{20'h10000, 20'h10001, 1'b0, 1'b0, 5, 1};
        vecs[1] = '{20'hFFFFF, 20'h00000, 1'b1, 1'b1, 5, 5};
        vecs[2] = '{20'h0FFFF, 20'h10000, 1'b0, 1'b0, 5, 5};
        vecs[3] = '{20'h00000, 20'h00001, 1'b0, 1'b0, 5, 1};
        vecs[4] = '{20'h12345, 20'h12346, 1'b0, 1'b0, 5, 1};
        vecs[5] = '{20'h000FF, 20'h00100, 1'b0, 1'b0, 5, 3};
        vecs[6] = '{20'hFFFFE, 20'hFFFFF, 1'b0, 1'b0, 5, 1};
        vecs[7] = '{20'h7FFFF, 20'h80000, 1'b0, 1'b0, 5, 5};

        // Asynchronous reset mid-cycle, no edge needed.
        #3 rst_n = 1'b0;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", {12'd0, incremented_output}, 32'd0);
        check("reset carry", {31'd0, carry_out}, 32'd0);
        check("reset zero", {31'd0, zero_flag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("idle busy", {31'd0, busy}, 32'd0);
            check("idle done", {31'd0, done}, 32'd0);
        end

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
`ifdef INC_SERIAL_EARLY_EXIT_EN
            run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].res, vecs[i].c, vecs[i].z,
                   vecs[i].cyc_early, -1);
`else
            run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].res, vecs[i].c, vecs[i].z,
                   vecs[i].cyc_fixed, -1);
`endif
        end

        // Start pulsed during CALC is ignored; then a fresh start is honoured.
        run_op("ignored start", 20'h0FABC, 20'h0FABD, 1'b0, 1'b0, model_cycles(20'h0FABC), 2);
        run_op("fresh start", 20'h12345, 20'h12346, 1'b0, 1'b0, model_cycles(20'h12345), -1);

        // Reset in the third cycle of an operation.
        @(negedge clk);
        start      = 1'b1;
        data_input = 20'h0FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midop reset busy", {31'd0, busy}, 32'd0);
        check("midop reset done", {31'd0, done}, 32'd0);
        check("midop reset result", {12'd0, incremented_output}, 32'd0);
        check("midop reset carry", {31'd0, carry_out}, 32'd0);
        check("midop reset zero", {31'd0, zero_flag}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_prev = '0;
        begin
            bit any_done;
            any_done = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                if (done || busy) any_done = 1'b1;
            end
            check("no done after abort", {31'd0, any_done}, 32'd0);
        end
        run_op("after abort", 20'h0FFFF, 20'h10000, 1'b0, 1'b0, model_cycles(20'h0FFFF), -1);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] d;
            logic [DW-1:0] r;
            int sel;
            sel = $urandom_range(0, 3);
            d   = DW'($urandom);
            if (sel == 1) d = d | (ALL_ONES >> (CW * $urandom_range(1, NC - 1)));
            if (sel == 2) d = ALL_ONES;
            r = d + 1'b1;
            run_op($sformatf("rand%0d", i), d, r, (d == ALL_ONES), (r == '0), model_cycles(d), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
